// File: rtl/frame_wr_ctrl.sv
// Capture-to-SDRAM write controller: buffers RGB565 pixels in a show-ahead FIFO
// and issues write bursts into one of two ping-pong frame banks.
module frame_wr_ctrl #(
    parameter int          BURST_LEN  = 256,
    parameter int          FRAME_PIX  = 921600,
    parameter logic [23:0] BANK1_BASE = 24'h100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sop,
    input  logic        eop,
    input  logic        vld,
    input  logic [15:0] pixel,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [23:0] wr_addr,
    output logic [8:0]  wr_len,
    input  logic        wr_data_req,
    output logic [15:0] wr_data,
    output logic        frame_done,
    output logic        wr_bank,
    output logic        ovf
);
    localparam int          DEPTH     = 2 * BURST_LEN;
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_CNT = (AW+1)'(BURST_LEN);
    localparam logic [8:0]  BURST_W   = 9'(BURST_LEN);
    localparam logic [19:0] FRAME_W   = 20'(FRAME_PIX);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          open_q, open_d, pend_q, pend_d;
    logic [19:0]   pix_q, pix_d;
    logic [23:0]   off_q;
    logic [8:0]    bcnt_q;
    logic          wr_req_q, done_q, bank_q, ovf_q;
    logic [23:0]   wr_addr_q;
    logic [8:0]    wr_len_q;
    logic          start, accept, full, push, pop, frame_end;

    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_len     = wr_len_q;
    assign frame_done = done_q;
    assign wr_bank    = bank_q;
    assign ovf        = ovf_q;
    assign wr_data    = mem_q[rptr_q];

    always_comb begin
        start     = vld && sop;
        accept    = vld && (sop || open_q);
        full      = (cnt_q == DEPTH_CNT);
        push      = accept && !full;
        pop       = wr_data_req && (state_q == DATA) && (cnt_q != '0);
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        pix_d     = pix_q;
        if (start)
            pix_d = 20'd1;
        else if (accept)
            pix_d = pix_q + 20'd1;
        // A frame closes on eop, or once FRAME_PIX pixels have been taken.
        frame_end = (open_q || start) && (eop || (accept && pix_d == FRAME_W));
        open_d    = open_q;
        pend_d    = pend_q;
        if (state_q == DONE)
            pend_d = 1'b0;
        if (start) begin
            open_d = 1'b1;
            pend_d = 1'b0;
        end
        if (frame_end) begin
            open_d = 1'b0;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= pixel;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            open_q    <= 1'b0;
            pend_q    <= 1'b0;
            pix_q     <= '0;
            off_q     <= '0;
            bcnt_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            done_q    <= 1'b0;
            bank_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            cnt_q  <= cnt_d;
            open_q <= open_d;
            pend_q <= pend_d;
            pix_q  <= pix_d;
            done_q <= 1'b0;
            if (accept && full)
                ovf_q <= 1'b1;
            if (start)
                off_q <= '0;
            case (state_q)
                IDLE: begin
                    // pend_q holds a closed frame whose frame_done is still owed.
                    if (cnt_q >= BURST_CNT || (pend_q && cnt_q != '0)) begin
                        state_q   <= REQ;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= (bank_q ? BANK1_BASE : 24'h0) + off_q;
                        wr_len_q  <= (cnt_q >= BURST_CNT) ? BURST_W : 9'(cnt_q);
                    end else if (pend_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (wr_ack) begin
                        state_q  <= DATA;
                        wr_req_q <= 1'b0;
                        bcnt_q   <= '0;
                    end
                end
                DATA: begin
                    if (pop) begin
                        bcnt_q <= bcnt_q + 9'd1;
                        if (bcnt_q == wr_len_q - 9'd1) begin
                            if (!start)
                                off_q <= off_q + 24'(wr_len_q);
                            if (pend_d && cnt_d == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                DONE: begin
                    bank_q  <= ~bank_q;
                    off_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Scoreboard bench for frame_wr_ctrl: a behavioural arbiter grants bursts and
// pulls words, checking burst headers and data against queued expectations.
module tb_frame_wr_ctrl;
    localparam int          BL = 8;
    localparam int          FP = 32;
    localparam logic [23:0] B1 = 24'h100000;

    typedef struct packed {
        logic [23:0] addr;
        logic [8:0]  len;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sop = 1'b0, eop = 1'b0, vld = 1'b0;
    logic [15:0] pixel = 16'h0;
    logic        wr_ack = 1'b0;
    logic        wr_data_req = 1'b0;
    logic        wr_req, frame_done, wr_bank, ovf;
    logic [23:0] wr_addr;
    logic [8:0]  wr_len;
    logic [15:0] wr_data;

    logic [15:0] exp_q[$];
    burst_t      exp_bq[$];
    burst_t      exp_b;
    logic [15:0] exp_w;
    int          n_cmp = 0, n_err = 0;
    int          arb_st = 0, beats = 0, bursts = 0, done_cnt = 0;
    bit          grant_en = 1'b0;

    frame_wr_ctrl #(.BURST_LEN(BL), .FRAME_PIX(FP), .BANK1_BASE(B1)) dut (
        .clk(clk), .rst_n(rst_n), .sop(sop), .eop(eop), .vld(vld), .pixel(pixel),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data_req(wr_data_req), .wr_data(wr_data),
        .frame_done(frame_done), .wr_bank(wr_bank), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Arbiter model: grants a pending request, then pulls wr_len words back to back.
    always @(negedge clk) begin
        wr_ack      = 1'b0;
        wr_data_req = 1'b0;
        if (frame_done) done_cnt++;
        if (rst_n) begin
            arb_st = 0;
            beats  = 0;
        end else if (arb_st == 0) begin
            if (wr_req && grant_en) begin
                n_cmp++;
                if (exp_bq.size() == 0) begin
                    n_err++;
                    $display("FAIL burst_hdr: got addr=%h len=%0d, expected no burst", wr_addr, wr_len);
                end else begin
                    exp_b = exp_bq.pop_front();
                    if (wr_addr !== exp_b.addr || wr_len !== exp_b.len) begin
                        n_err++;
                        $display("FAIL burst_hdr: got addr=%h len=%0d, expected addr=%h len=%0d",
                                 wr_addr, wr_len, exp_b.addr, exp_b.len);
                    end
                end
                wr_ack = 1'b1;
                beats  = int'(wr_len);
                bursts++;
                arb_st = (beats > 0) ? 1 : 0;
            end
        end else begin
            wr_data_req = 1'b1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_data: got %h, expected no word", wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (wr_data !== exp_w) begin
                    n_err++;
                    $display("FAIL wr_data: got %h expected %h", wr_data, exp_w);
                end
            end
            beats--;
            if (beats == 0) arb_st = 0;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b1;
        sop = 1'b0; eop = 1'b0; vld = 1'b0; pixel = 16'h0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_bq.delete();
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pixels(input int n, input logic [15:0] base, input bit do_sop,
                               input bit do_eop, input int n_exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vld   = 1'b1;
            pixel = base + 16'(i);
            sop   = do_sop && (i == 0);
            eop   = do_eop && (i == n - 1);
            if (i < n_exp) exp_q.push_back(pixel);
        end
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start_cnt = done_cnt;
        int k = 0;
        while (done_cnt == start_cnt && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done_cnt == start_cnt) begin
            n_err++;
            $display("FAIL %s_done: frame_done not seen within %0d cycles", name, k);
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || exp_bq.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words / %0d bursts left, expected 0 / 0",
                     name, exp_q.size(), exp_bq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({wr_req, wr_addr, wr_len, frame_done, wr_bank, ovf} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b addr=%h len=%0d done=%b bank=%b ovf=%b, expected all 0",
                     wr_req, wr_addr, wr_len, frame_done, wr_bank, ovf);
        end
        apply_reset();
    endtask

    task automatic test_full_frame();
        apply_reset();
        grant_en = 1'b1;
        for (int b = 0; b < 4; b++) exp_bq.push_back('{24'(b * 8), 9'd8});
        send_pixels(32, 16'h1000, 1'b1, 1'b1, 32);
        wait_done("full");
        n_cmp++;
        if (wr_bank !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL full_bank: got bank=%b ovf=%b expected bank=1 ovf=0", wr_bank, ovf);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_pulse: frame_done got %b expected 0 one cycle later", frame_done);
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        grant_en = 1'b1;
        exp_bq.push_back('{24'd0, 9'd8});
        exp_bq.push_back('{24'd8, 9'd8});
        exp_bq.push_back('{24'd16, 9'd4});
        send_pixels(20, 16'h2000, 1'b1, 1'b1, 20);
        wait_done("short");
    endtask

    task automatic test_pre_sop();
        apply_reset();
        grant_en = 1'b1;
        exp_bq.push_back('{24'd0, 9'd8});
        send_pixels(5, 16'hE000, 1'b0, 1'b0, 0);
        send_pixels(8, 16'h0500, 1'b1, 1'b1, 8);
        wait_done("presop");
    endtask

    task automatic test_backpressure();
        int bad = 0;
        apply_reset();
        grant_en = 1'b0;
        exp_bq.push_back('{24'd0, 9'd8});
        exp_bq.push_back('{24'd8, 9'd8});
        send_pixels(24, 16'h3000, 1'b1, 1'b1, 16);
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ovf: got %b expected 1", ovf);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (wr_req !== 1'b1 || wr_addr !== 24'd0 || wr_len !== 9'd8) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_req_stable: %0d unstable cycles, last req=%b addr=%h len=%0d, expected 0",
                     bad, wr_req, wr_addr, wr_len);
        end
        grant_en = 1'b1;
        wait_done("bp");
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ovf_sticky: got %b expected 1", ovf);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        grant_en = 1'b1;
        exp_bq.push_back('{24'd0, 9'd8});
        send_pixels(8, 16'h4000, 1'b1, 1'b1, 8);
        wait_done("b2b_a");
        n_cmp++;
        if (wr_bank !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_bank_a: got %b expected 1", wr_bank);
        end
        exp_bq.push_back('{B1, 9'd8});
        send_pixels(8, 16'h4100, 1'b1, 1'b1, 8);
        wait_done("b2b_b");
        n_cmp++;
        if (wr_bank !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_bank_b: got %b expected 0", wr_bank);
        end
    endtask

    task automatic test_reset_mid();
        int  b0;
        bit  hit = 1'b0;
        apply_reset();
        grant_en = 1'b1;
        b0 = bursts;
        exp_bq.push_back('{24'd0, 9'd8});
        exp_bq.push_back('{24'd8, 9'd8});
        for (int i = 0; i < 24 && !hit; i++) begin
            @(negedge clk);
            if (bursts - b0 >= 2 && arb_st == 1 && beats < BL) begin
                hit   = 1'b1;
                rst_n = 1'b1;
                vld = 1'b0; sop = 1'b0; eop = 1'b0;
            end else begin
                vld   = 1'b1;
                pixel = 16'h5000 + 16'(i);
                sop   = (i == 0);
                exp_q.push_back(pixel);
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL mid_reached: second burst DATA got not reached, expected reached");
            rst_n = 1'b1;
            vld = 1'b0; sop = 1'b0; eop = 1'b0;
        end
        #1;
        n_cmp++;
        if ({wr_req, wr_addr, wr_len, frame_done, wr_bank, ovf} !== 38'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got req=%b addr=%h len=%0d done=%b bank=%b ovf=%b, expected all 0",
                     wr_req, wr_addr, wr_len, frame_done, wr_bank, ovf);
        end
        apply_reset();
        exp_bq.push_back('{24'd0, 9'd8});
        send_pixels(8, 16'h6000, 1'b1, 1'b1, 8);
        wait_done("mid_next");
        n_cmp++;
        if (wr_bank !== 1'b1) begin
            n_err++;
            $display("FAIL mid_next_bank: got %b expected 1", wr_bank);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_pre_sop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_wr_ctrl.md
FRAME_WR_CTRL -- requirements
Module: frame_wr_ctrl

Interface
REQ-001 SHALL take parameter BURST_LEN, default 256: words per full SDRAM write burst, power of two, at most 256.
REQ-002 SHALL take parameter FRAME_PIX, default 921600 (1280x720): pixels per frame.
REQ-003 SHALL take parameter BANK1_BASE, default 24'h100000: word base address of bank 1; bank 0 base is 0.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-high (asserted at 1).
REQ-006 SHALL have ports sop, eop, vld, input, 1 bit each: capture-stage frame start, frame end, pixel valid strobes.
REQ-007 SHALL have port pixel, input, 16 bits: RGB565 pixel, sampled when vld=1.
REQ-008 SHALL have port wr_req, output, 1 bit: burst request to the SDRAM arbiter.
REQ-009 SHALL have port wr_ack, input, 1 bit: arbiter grant, single-cycle pulse.
REQ-010 SHALL have ports wr_addr (output, 24 bits) and wr_len (output, 9 bits): burst start word address and burst word count.
REQ-011 SHALL have port wr_data_req, input, 1 bit: arbiter pulls one word per asserted cycle.
REQ-012 SHALL have port wr_data, output, 16 bits: current FIFO head word.
REQ-013 SHALL have ports frame_done (1-cycle pulse), wr_bank (bank being written) and ovf (sticky overflow), all outputs, 1 bit each.

Function
REQ-014 SHALL buffer pixels in a show-ahead FIFO, depth 2*BURST_LEN x 16; wr_data presents the head word combinationally, and each wr_data_req cycle pops it.
REQ-015 SHALL discard vld pixels until a vld cycle with sop=1; that pixel is the first one written; pixel acceptance runs from that cycle until eop.
REQ-016 SHALL keep a 20-bit accepted-pixel counter; it clears at sop.
REQ-017 SHALL treat sop arriving while a frame is still open as a new frame: it restarts the pixel counter and the address offset; words already in the FIFO are still written.
REQ-018 SHALL, when the FIFO is full and a vld pixel arrives, drop that pixel and set ovf; ovf clears only on reset.
REQ-019 SHALL run FSM states IDLE, REQ, DATA, DONE.
REQ-020 SHALL move IDLE->REQ when FIFO count >= BURST_LEN, or when the frame has closed and count > 0; wr_len is min(count, BURST_LEN), latched on entry.
REQ-021 SHALL, in REQ, hold wr_req=1 with wr_addr and wr_len stable, and move to DATA on wr_ack.
REQ-022 SHALL, in DATA, count popped words; after wr_len pops, advance the address offset by wr_len and go to IDLE, or to DONE if the frame has closed and the FIFO is empty.
REQ-023 SHALL treat wr_data_req with the FIFO empty, or outside DATA, as a protocol error: it is ignored and does not pop.
REQ-024 SHALL generate wr_addr = bank base + offset, 24 bits, with no wrap inside a frame.
REQ-025 SHALL, in DONE, pulse frame_done for one cycle, toggle wr_bank, clear the offset, and return to IDLE.
REQ-026 SHALL process a simultaneous push and pop in the same cycle, leaving the FIFO count unchanged.
REQ-027 SHALL have a latency of exactly 1 clock from wr_ack to the DATA state; wr_data is valid in the same cycle as wr_data_req.

Reset
REQ-028 SHALL, while rst_n=1, asynchronously force: FSM=IDLE, FIFO empty, wr_req=0, wr_addr=0, wr_len=0, frame_done=0, wr_bank=0, ovf=0, offset=0, frame closed.
REQ-029 SHALL discard any partial frame and any in-flight burst when reset is asserted mid-operation; the first frame after reset starts at a fresh sop.

Verification
REQ-030 SHALL pass a bench using BURST_LEN=8, FRAME_PIX=32 with 32 vld pixels (sop on the first, eop on the last) and immediate grant -> four bursts at wr_addr 0, 8, 16, 24, each with wr_len=8, then frame_done, and wr_bank=1.
REQ-031 SHALL pass a bench with 20 pixels then eop -> bursts of wr_len 8, 8, 4 at addresses 0, 8, 16, then frame_done.
REQ-032 SHALL pass a bench with 5 vld pixels before sop, then a normal frame -> the pre-sop pixels are never output, and the first wr_data equals the sop pixel.
REQ-033 SHALL pass a bench with wr_ack withheld for 40 cycles while 24 pixels stream -> FIFO fills to 16, ovf=1, the first 16 pixels are output in order, and wr_req stays stable throughout.
REQ-034 SHALL pass a bench of two back-to-back frames -> the second frame writes at BANK1_BASE, and wr_bank returns to 0 after its frame_done.
REQ-035 SHALL pass a bench asserting rst_n during DATA of the second burst -> all outputs take reset values immediately, and the next frame restarts at address 0.
